// File: rtl/full_adder_1bit.sv
// 1-bit full adder stage for the 4-bit ripple adder/subtractor.
// sum/cout are pure gate logic so a chain of stages settles within one clock.
// A registered copy of sum/cout plus a valid flag is also provided for
// pipelined or observed use. The ripple chain uses only the combinational outputs.
module full_adder_1bit (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout,
   input  logic vld_i,
   output logic sum_q,
   output logic cout_q,
   output logic vld_q
);

   // Plain gate expressions, so X/Z on any input propagates by gate
   // semantics instead of being masked.
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

   // Capture the stage result only when vld_i qualifies the inputs.
   // vld_q follows vld_i every cycle.
   // Reset clears the registered outputs at once and drops any pending capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= 1'b0;
         cout_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= vld_i;
         if (vld_i) begin
            sum_q  <= sum;
            cout_q <= cout;
         end
      end
   end

endmodule

// File: tb/tb_full_adder_1bit.sv
// Directed and random checks of the 1-bit full adder stage.
// A 4-stage chain is also checked as a ripple adder/subtractor.
module tb_full_adder_1bit;

   logic clk;
   logic rst_n;
   logic a, b, cin, vld_i;
   logic sum, cout, sum_q, cout_q, vld_q;

   int total = 0;
   int bad   = 0;

   full_adder_1bit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .sum    (sum),
      .cout   (cout),
      .vld_i  (vld_i),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .vld_q  (vld_q)
   );

   // 4-stage ripple chain: {c[4], rs} = ra + (rb ^ {4{rm}}) + rm
   logic [3:0] ra, rb, rs;
   logic       rm;
   logic [4:0] c;
   logic [3:0] r_sq, r_cq, r_vq;

   assign c[0] = rm;

   for (genvar i = 0; i < 4; i++) begin : g_rip
      full_adder_1bit u_fa (
         .clk    (clk),
         .rst_n  (rst_n),
         .a      (ra[i]),
         .b      (rb[i] ^ rm),
         .cin    (c[i]),
         .sum    (rs[i]),
         .cout   (c[i+1]),
         .vld_i  (1'b0),
         .sum_q  (r_sq[i]),
         .cout_q (r_cq[i]),
         .vld_q  (r_vq[i])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rip(input logic [3:0] xa, input logic [3:0] xb, input logic xm,
                      input logic [4:0] exp, input string tag);
      ra = xa;
      rb = xb;
      rm = xm;
      #1;
      chk(tag, {3'b0, c[4], rs}, {3'b0, exp});
   endtask

   logic [7:0] tt_sum;
   logic [7:0] tt_cout;
   logic [2:0] idx;
   logic       m_sq, m_cq, m_vq;
   logic [1:0] m_add;

   initial begin
      tt_sum  = 8'b1001_0110;
      tt_cout = 8'b1110_1000;
      rst_n = 1'b0;
      a = 1'b0; b = 1'b0; cin = 1'b0; vld_i = 1'b0;
      ra = 4'd0; rb = 4'd0; rm = 1'b0;

      // Reset state, with the combinational path live during reset
      #2;
      chk("rst_sum_q",  {7'b0, sum_q},  8'd0);
      chk("rst_cout_q", {7'b0, cout_q}, 8'd0);
      chk("rst_vld_q",  {7'b0, vld_q},  8'd0);
      a = 1'b1; b = 1'b1; cin = 1'b0;
      #1;
      chk("rst_comb", {6'b0, cout, sum}, 8'b10);

      // Exhaustive truth table
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         {a, b, cin} = idx;
         #1;
         chk($sformatf("tt_sum_%0d", i),  {7'b0, sum},  {7'b0, tt_sum[idx]});
         chk($sformatf("tt_cout_%0d", i), {7'b0, cout}, {7'b0, tt_cout[idx]});
      end

      // X propagates through the sum but a 1,1 majority still forces cout
      a = 1'bx; b = 1'b1; cin = 1'b1;
      #1;
      chk("x_sum",  {7'b0, sum},  {7'b0, 1'bx});
      chk("x_cout", {7'b0, cout}, 8'd1);

      // Registered path
      @(negedge clk);
      rst_n = 1'b1;
      vld_i = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b1;
      @(posedge clk); #1;
      chk("reg_sum_q",  {7'b0, sum_q},  8'd0);
      chk("reg_cout_q", {7'b0, cout_q}, 8'd1);
      chk("reg_vld_q",  {7'b0, vld_q},  8'd1);
      @(negedge clk);
      vld_i = 1'b0; a = 1'b1; b = 1'b1; cin = 1'b1;
      @(posedge clk); #1;
      chk("hold_sum_q",  {7'b0, sum_q},  8'd0);
      chk("hold_cout_q", {7'b0, cout_q}, 8'd1);
      chk("hold_vld_q",  {7'b0, vld_q},  8'd0);
      @(negedge clk);
      vld_i = 1'b1;
      @(posedge clk); #1;
      chk("b2b_sum_q",  {7'b0, sum_q},  8'd1);
      chk("b2b_cout_q", {7'b0, cout_q}, 8'd1);
      chk("b2b_vld_q",  {7'b0, vld_q},  8'd1);

      // Async reset between edges
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_q",    {5'b0, sum_q, cout_q, vld_q}, 8'd0);
      chk("arst_comb", {6'b0, cout, sum}, 8'b11);
      @(posedge clk); #1;
      chk("arst_hold_q", {5'b0, sum_q, cout_q, vld_q}, 8'd0);

      // 4-stage ripple
      rip(4'b0101, 4'b0011, 1'b0, 5'b0_1000, "rip_add_5_3");
      rip(4'd4,    4'd5,    1'b0, 5'b0_1001, "rip_add_4_5");
      rip(4'd15,   4'd1,    1'b0, 5'b1_0000, "rip_add_15_1");
      rip(4'd3,    4'd2,    1'b1, 5'b1_0001, "rip_sub_3_2");
      rip(4'd2,    4'd3,    1'b1, 5'b0_1111, "rip_sub_2_3");
      rip(4'd7,    4'd7,    1'b1, 5'b1_0000, "rip_sub_7_7");

      // Random with occasional async reset, against an arithmetic model
      m_sq = 1'b0; m_cq = 1'b0; m_vq = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a     = 1'($urandom);
         b     = 1'($urandom);
         cin   = 1'($urandom);
         vld_i = 1'($urandom);
         rst_n = ($urandom_range(0, 39) != 0);
         #1;
         m_add = 2'(a) + 2'(b) + 2'(cin);
         chk("rnd_comb", {6'b0, cout, sum}, {6'b0, m_add});
         if (!rst_n) begin
            m_sq = 1'b0; m_cq = 1'b0; m_vq = 1'b0;
            chk("rnd_arst_q", {5'b0, sum_q, cout_q, vld_q}, 8'd0);
         end
         @(posedge clk);
         if (rst_n) begin
            m_vq = vld_i;
            if (vld_i) begin
               m_sq = m_add[0];
               m_cq = m_add[1];
            end
         end
         #1;
         chk("rnd_q", {5'b0, sum_q, cout_q, vld_q}, {5'b0, m_sq, m_cq, m_vq});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
